// File: rtl/subword_mem_ctrl.sv
// Load/store sequencer for a word-only memory port. Sub-word stores are done
// as read-modify-write. Sub-word loads return the addressed lane, zero- or
// sign-extended. Lanes are big-endian: byte offset 0 is bits [31:24].
module subword_mem_ctrl #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // Bit position of the lane's LSB inside the word (big-endian numbering).
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    logic [4:0] sh;
    case (size)
      2'b00:   sh = {2'd3 - off, 3'b000};
      2'b01:   sh = {~off[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  // Right-aligned mask covering one lane of the given size.
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      2'b00:   m = 32'h0000_00FF;
      2'b01:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Pull the addressed lane down to bit 0 and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [31:0] raw;
    logic [31:0] res;
    raw = (word >> lane_shift(size, off)) & lane_mask(size);
    case (size)
      2'b00:   res = sgn ? {{24{raw[7]}}, raw[7:0]} : raw;
      2'b01:   res = sgn ? {{16{raw[15]}}, raw[15:0]} : raw;
      default: res = raw;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of old_word with the low bits of new_data.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word, input logic [31:0] new_data,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = lane_mask(size) << lane_shift(size, off);
    return (old_word & ~m) | ((new_data & lane_mask(size)) << lane_shift(size, off));
  endfunction

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               acked_s;
  logic               tmo_hit_s;
  logic               bad_req_s;

  // Next-state, output and request-latch logic of the sequencer.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    tmo_cnt_d    = tmo_cnt_q;
    // mem_ack only counts while a request is actually on the port.
    acked_s      = mem_req_q & mem_ack;
    tmo_hit_s    = (TIMEOUT != 0) && mem_req_q && !mem_ack && (tmo_cnt_q == TMO_LAST);
    bad_req_s    = (req_size == 2'b11) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                   ((req_size == 2'b01) && req_addr[0]);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          sgn_d      = req_signed;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          tmo_cnt_d  = '0;
          if (bad_req_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_size == 2'b10)) begin
            state_d     = WR;
            mem_addr_d  = req_addr[ADDR_W+1:2];
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RD;
            mem_addr_d = req_addr[ADDR_W+1:2];
            mem_we_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (acked_s) begin
          tmo_cnt_d = '0;
          if (we_q) begin
            // Read half of RMW done: the request line drops for a cycle.
            state_d     = WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = merge_lane(mem_rdata, wdata_q, size_q, off_q);
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = extract_lane(mem_rdata, size_q, off_q, sgn_q);
          end
        end else if (tmo_hit_s) begin
          // Abort: a timed-out RMW read never proceeds to the write.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          if (mem_req_q && (TIMEOUT != 0)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q;
          end
        end
      end
      WR: begin
        if (acked_s) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          mem_we_d     = 1'b0;
        end else if (tmo_hit_s) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          mem_we_d     = 1'b0;
        end else begin
          mem_req_d = 1'b1;
          if (mem_req_q && (TIMEOUT != 0)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q;
          end
        end
      end
      RESP: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; async reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'd0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Directed bench for subword_mem_ctrl with a small word memory on its port.
module tb_subword_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        ack_en = 1'b1;
  logic        ack_force = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] mem_arr [0:255];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int req_cyc = 0;
  int wreq_cyc = 0;

  int checks = 0;
  int failures = 0;

  subword_mem_ctrl #(.ADDR_W(30), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign mem_ack   = ack_force | (ack_en & mem_req);
  assign mem_rdata = mem_arr[mem_addr[7:0]];

  // Memory model plus access counters.
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (mem_req && mem_we && mem_ack) mem_arr[mem_addr[7:0]] <= mem_wdata;
    if (mem_req && mem_ack) begin
      if (mem_we) wr_cnt <= wr_cnt + 1;
      else rd_cnt <= rd_cnt + 1;
    end
    if (mem_req) req_cyc <= req_cyc + 1;
    if (mem_req && mem_we) wreq_cyc <= wreq_cyc + 1;
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
    if (resp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL resp_wait: no resp_valid within %0d cycles (addr %h)", lat, addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      failures++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0/0/0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
      failures++; $display("FAIL reset_mem: got req=%b we=%b a=%h d=%h want zeros", mem_req, mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    int lat; logic [31:0] rd; logic err;
    preload(8'h10, 32'h1122_3344);
    do_req(1'b0, 2'b00, 1'b1, 32'h41, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'h0000_0022 || err !== 1'b0) begin failures++; $display("FAIL load_byte41: got %h err=%b want 00000022 err=0", rd, err); end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL load_latency: got %0d want 3", lat); end
    do_req(1'b0, 2'b00, 1'b1, 32'h43, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'h0000_0044) begin failures++; $display("FAIL load_byte43: got %h want 00000044", rd); end
    preload(8'h10, 32'h80FF_1234);
    do_req(1'b0, 2'b01, 1'b1, 32'h40, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'hFFFF_80FF) begin failures++; $display("FAIL load_half_s: got %h want FFFF80FF", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h40, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'h0000_80FF) begin failures++; $display("FAIL load_half_u: got %h want 000080FF", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h40, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL load_byte40_s: got %h want FFFFFF80", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'h0000_1234) begin failures++; $display("FAIL load_half42: got %h want 00001234", rd); end
    do_req(1'b0, 2'b10, 1'b1, 32'h40, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'h80FF_1234 || lat != 3) begin failures++; $display("FAIL load_word: got %h lat=%0d want 80FF1234 lat=3", rd, lat); end
  endtask

  task automatic test_store_sub();
    int lat; logic [31:0] rd; logic err; int r0; int w0;
    preload(8'h10, 32'h1122_3344);
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h42, 32'h0000_00AB, lat, rd, err);
    checks++;
    if (mem_arr[8'h10] !== 32'h1122_AB44) begin failures++; $display("FAIL store_byte: got %h want 1122AB44", mem_arr[8'h10]); end
    checks++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1) begin failures++; $display("FAIL store_byte_acc: got rd=%0d wr=%0d want 1/1", rd_cnt - r0, wr_cnt - w0); end
    checks++;
    if (lat != 5 || err !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL store_byte_resp: got lat=%0d err=%b d=%h want 5/0/0", lat, err, rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h40, 32'hFFFF_BEEF, lat, rd, err);
    checks++;
    if (mem_arr[8'h10] !== 32'hBEEF_AB44) begin failures++; $display("FAIL store_half: got %h want BEEFAB44", mem_arr[8'h10]); end
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] rd; logic err; int r0; int w0;
    preload(8'h11, 32'h0000_0000);
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF, lat, rd, err);
    checks++;
    if (mem_arr[8'h11] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_word: got %h want DEADBEEF", mem_arr[8'h11]); end
    checks++;
    if (rd_cnt - r0 != 0 || wr_cnt - w0 != 1 || lat != 3) begin
      failures++; $display("FAIL store_word_acc: got rd=%0d wr=%0d lat=%0d want 0/1/3", rd_cnt - r0, wr_cnt - w0, lat);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic err; int c0;
    logic        we_v [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz_v [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad_v [3] = '{32'h43, 32'h42, 32'h40};
    for (int i = 0; i < 3; i++) begin
      c0 = req_cyc;
      do_req(we_v[i], sz_v[i], 1'b0, ad_v[i], 32'h1234_5678, lat, rd, err);
      checks++;
      if (lat != 1 || err !== 1'b1 || rd !== 32'd0 || req_cyc != c0) begin
        failures++; $display("FAIL error_%0d: got lat=%0d err=%b d=%h memreq=%0d want 1/1/0/0", i, lat, err, rd, req_cyc - c0);
      end
    end
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] rd; logic err; int c0; int w0; int wc0;
    preload(8'h10, 32'hCAFE_F00D);
    ack_en = 1'b0;
    c0 = req_cyc;
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, lat, rd, err);
    checks++;
    if (req_cyc - c0 != 4 || err !== 1'b1 || lat != 6) begin
      failures++; $display("FAIL timeout_load: got memreq=%0d err=%b lat=%0d want 4/1/6", req_cyc - c0, err, lat);
    end
    c0 = req_cyc; w0 = wr_cnt; wc0 = wreq_cyc;
    do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_0077, lat, rd, err);
    checks++;
    if (req_cyc - c0 != 4 || wreq_cyc != wc0 || wr_cnt != w0 || err !== 1'b1) begin
      failures++; $display("FAIL timeout_rmw: got memreq=%0d wreq=%0d err=%b want 4/0/1", req_cyc - c0, wreq_cyc - wc0, err);
    end
    checks++;
    if (mem_arr[8'h10] !== 32'hCAFE_F00D) begin failures++; $display("FAIL timeout_mem: got %h want CAFEF00D", mem_arr[8'h10]); end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err; int w0;
    preload(8'h12, 32'h0BAD_0BAD);
    ack_en = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h48; req_wdata = 32'h55AA_55AA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL mid_wr: got req=%b we=%b want 1/1", mem_req, mem_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL async_reset: got req=%b ready=%b want 0/1", mem_req, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    checks++;
    if (mem_arr[8'h12] !== 32'h0BAD_0BAD || wr_cnt != w0) begin failures++; $display("FAIL reset_mem_kept: got %h want 0BAD0BAD", mem_arr[8'h12]); end
    do_req(1'b0, 2'b00, 1'b0, 32'h49, 32'd0, lat, rd, err);
    checks++;
    if (rd !== 32'h0000_00AD || err !== 1'b0 || lat != 3) begin
      failures++; $display("FAIL after_reset: got %h err=%b lat=%0d want 000000AD/0/3", rd, err, lat);
    end
  endtask

  task automatic test_ack_ignored();
    int lat; logic [31:0] rd; logic err;
    preload(8'h13, 32'h0102_0304);
    ack_en = 1'b0; ack_force = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h4C, 32'd0, lat, rd, err);
    checks++;
    if (lat != 3 || rd !== 32'h0102_0304) begin failures++; $display("FAIL ack_ign_load: got lat=%0d d=%h want 3/01020304", lat, rd); end
    do_req(1'b1, 2'b00, 1'b0, 32'h4D, 32'h0000_00EE, lat, rd, err);
    checks++;
    if (lat != 5 || mem_arr[8'h13] !== 32'h01EE_0304) begin failures++; $display("FAIL ack_ign_store: got lat=%0d m=%h want 5/01EE0304", lat, mem_arr[8'h13]); end
    ack_force = 1'b0; ack_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic prev = 1'b0;
    logic dbl = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h4C;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b want 0", req_ready); end
      end
      if (resp_valid === 1'b1) begin
        pulses++;
        if (prev) dbl = 1'b1;
      end
      prev = (resp_valid === 1'b1);
    end
    req_valid = 1'b0;
    checks++;
    if (pulses != 2 || dbl) begin failures++; $display("FAIL back_to_back: got pulses=%0d double=%b want 2/0", pulses, dbl); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: got ready=%b v=%b want 1/0", req_ready, resp_valid); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_sub();
    test_store_word();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_ack_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
